dff_rr_sched: RTL and testbench

DFF_RR_SCHED -- requirements
Module: dff_rr_sched

---
 rtl/dff_sched_pkg.sv | 12 +
 rtl/rr_arb.sv | 31 +++
 rtl/dff_rr_sched.sv | 100 ++++++++++
 tb/tb_dff_rr_sched.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/dff_sched_pkg.sv
// rtl/dff_sched_pkg.sv - shared types and defaults for the shared-DFF round-robin scheduler
package dff_sched_pkg;

  localparam int NREQ_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FLUSH = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arb.sv
// rtl/rr_arb.sv - one-hot round-robin arbiter, search starts at ptr
module rr_arb #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);

  int j;

  // Walk the requesters from ptr upward (wrapping) and pick the first one asserted.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/dff_rr_sched.sv
// rtl/dff_rr_sched.sv - round-robin scheduler time-sharing one external D flip-flop
module dff_rr_sched
  import dff_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     flush,
  output logic                     dff_din,
  output logic                     dff_rst,
  input  logic                     dff_dout,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic                     rsp_data
);

  localparam int IW = $clog2(NREQ);

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   rsp_id_q, rsp_id_d;

  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gnt_idx;
  logic            gnt_any;
  logic            grant_en;
  logic            xfer;

  rr_arb #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  // Handshake and flip-flop drive: reset and flush override everything, otherwise
  // the flop either takes the granted bit or recirculates its own content.
  always_comb begin
    grant_en  = rst_n && !flush &&
                ((state_q == IDLE) || ((state_q == PEND) && rsp_ready));
    req_ready = grant_en ? gnt : '0;
    xfer      = grant_en && gnt_any;
    rsp_valid = rst_n && !flush && (state_q == PEND);
    rsp_data  = dff_dout;
    rsp_id    = rsp_id_q;
    dff_rst   = !rst_n || flush;
    if (!rst_n) begin
      dff_din = 1'b0;
    end else if (xfer) begin
      dff_din = req_data[gnt_idx];
    end else begin
      dff_din = dff_dout;
    end
  end

  // Next state: flush wins, a transfer always lands in PEND, a drained response with
  // no new transfer returns to IDLE, and FLUSH lasts exactly one cycle once released.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    rsp_id_d = rsp_id_q;
    if (flush) begin
      state_d = FLUSH;
    end else begin
      case (state_q)
        IDLE:    if (xfer) state_d = PEND;
        PEND:    if (rsp_ready && !xfer) state_d = IDLE;
        FLUSH:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
      if (xfer) begin
        ptr_d    = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
        rsp_id_d = gnt_idx;
      end
    end
  end

  // State, pointer and response id registers; async reset discards any pending response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      rsp_id_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      rsp_id_q <= rsp_id_d;
    end
  end

endmodule

// File: tb/tb_dff_rr_sched.sv
// tb/tb_dff_rr_sched.sv - self-checking bench for dff_rr_sched with an external DFF model
module tb_dff_rr_sched;

  logic       clk;
  logic       rst_n;
  logic [3:0] req_valid;
  logic [3:0] req_data;
  logic [3:0] req_ready;
  logic       flush;
  logic       dff_din;
  logic       dff_rst;
  logic       dff_dout;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [1:0] rsp_id;
  logic       rsp_data;

  int checks = 0;
  int errors = 0;

  int         m_st  = 0;
  int         m_ptr = 0;
  logic [2:0] sb_q[$];

  dff_rr_sched #(.NREQ(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .flush     (flush),
    .dff_din   (dff_din),
    .dff_rst   (dff_rst),
    .dff_dout  (dff_dout),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External shared flip-flop with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (dff_rst) dff_dout <= 1'b0;
    else         dff_dout <= dff_din;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] rr_exp(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) begin
      if (v[(p + k) % 4]) return 4'b0001 << ((p + k) % 4);
    end
    return 4'b0000;
  endfunction

  function automatic int oh_idx(input logic [3:0] g);
    for (int k = 0; k < 4; k++) if (g[k]) return k;
    return 0;
  endfunction

  task automatic cyc();
    logic [3:0] eg;
    logic [2:0] e;
    int         gi;
    #2;
    eg = 4'b0000;
    if (!flush && (m_st == 0 || (m_st == 1 && rsp_ready))) eg = rr_exp(req_valid, m_ptr);
    gi = oh_idx(eg);
    check_eq("req_ready", 32'(req_ready), 32'(eg));
    check_eq("rsp_valid", 32'(rsp_valid), 32'(m_st == 1 && !flush));
    check_eq("dff_rst", 32'(dff_rst), 32'(flush));
    if (m_st == 2) check_eq("flush_dout", 32'(dff_dout), 32'(0));
    if (eg != 4'b0000)  check_eq("dff_din_wr", 32'(dff_din), 32'(req_data[gi]));
    else if (!flush)    check_eq("dff_din_hold", 32'(dff_din), 32'(dff_dout));
    if (m_st == 1 && !flush) begin
      check_eq("sb_size", 32'(sb_q.size()), 32'(1));
      if (sb_q.size() != 0) begin
        e = sb_q[0];
        check_eq("rsp_id", 32'(rsp_id), 32'(e[2:1]));
        check_eq("rsp_data", 32'(rsp_data), 32'(e[0]));
        if (rsp_ready) void'(sb_q.pop_front());
      end
    end
    if (flush) begin
      sb_q.delete();
      m_st = 2;
    end else if (eg != 4'b0000) begin
      sb_q.push_back({2'(gi), req_data[gi]});
      m_ptr = (gi + 1) % 4;
      m_st  = 1;
    end else if (m_st == 1 && rsp_ready) begin
      m_st = 0;
    end else if (m_st == 2) begin
      m_st = 0;
    end
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_st  = 0;
    m_ptr = 0;
    sb_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [3:0] seq [5];
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst_n = 1'b0; req_valid = '0; req_data = '0; flush = 1'b0; rsp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    req_valid = 4'b1111;
    #2;
    check_eq("rst_req_ready", 32'(req_ready), 32'(0));
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check_eq("rst_dff_rst", 32'(dff_rst), 32'(1));
    check_eq("rst_dff_din", 32'(dff_din), 32'(0));
    check_eq("rst_rsp_id", 32'(rsp_id), 32'(0));
    check_eq("rst_rsp_data", 32'(rsp_data), 32'(dff_dout));
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // round robin with all requesters active
    req_valid = 4'b1111; req_data = 4'b0101; rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("rr_seq", 32'(req_ready), 32'(seq[i]));
      cyc();
    end
    req_valid = 4'b0000;
    cyc();

    // requester 2 writes 1 then 0
    req_valid = 4'b0100; req_data = 4'b0100; cyc();
    req_data = 4'b0000; cyc();
    req_valid = 4'b0000; cyc();

    // backpressure with response data 1
    req_valid = 4'b0100; req_data = 4'b0100; rsp_ready = 1'b1; cyc();
    req_valid = 4'b1111; req_data = 4'b0000; rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
    req_valid = 4'b0000; rsp_ready = 1'b1; cyc();

    // flush while a response holding 1 is pending
    req_valid = 4'b0010; req_data = 4'b0010; cyc();
    req_valid = 4'b1111; flush = 1'b1; cyc();
    flush = 1'b0; req_valid = 4'b0000; cyc();
    cyc();

    // flush and request in the same cycle, then flush held two cycles
    req_valid = 4'b0100; req_data = 4'b0100; flush = 1'b1; cyc();
    flush = 1'b0; cyc();
    req_valid = 4'b1111; cyc();
    flush = 1'b1; cyc(); cyc();
    flush = 1'b0; cyc();
    req_valid = 4'b0000; cyc(); cyc();

    // random traffic
    for (int i = 0; i < 60; i++) begin
      req_valid = 4'($urandom);
      req_data  = 4'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      cyc();
    end
    flush = 1'b0; rsp_ready = 1'b1; req_valid = 4'b0000; cyc();

    // asynchronous reset while a response is pending, pointer left non-zero
    req_valid = 4'b0100; req_data = 4'b0100; cyc();
    req_valid = 4'b0000;
    #3 rst_n = 1'b0;
    #1;
    check_eq("arst_rsp_valid", 32'(rsp_valid), 32'(0));
    check_eq("arst_req_ready", 32'(req_ready), 32'(0));
    check_eq("arst_dff_rst", 32'(dff_rst), 32'(1));
    check_eq("arst_dff_din", 32'(dff_din), 32'(0));
    @(negedge clk);
    check_eq("arst_dout", 32'(dff_dout), 32'(0));
    rst_n = 1'b1;
    model_reset();
    req_valid = 4'b1111;
    #1;
    check_eq("arst_ptr0", 32'(req_ready), 32'(4'b0001));
    cyc();
    req_valid = 4'b0000; cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
